// File: rtl/lcd_fixed_formatter.sv
// lcd_fixed_formatter: formats NCH fixed-point values as ASCII lines, one char write per cycle.
// Optional LCD_FMT_LEADZ_BLANK_EN blanks leading zero integer digits (units digit always shown).
module lcd_fixed_formatter #(
  parameter int NCH  = 2,
  parameter int W    = 32,
  parameter int FRAC = 16,
  parameter int IDIG = 5,
  parameter int FDIG = 4,
  parameter int LINE = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [W*NCH-1:0]                     values,
  input  logic [NCH-1:0]                       is_signed,
  input  logic [8*NCH-1:0]                     labels,
  output logic                                 busy,
  output logic                                 done,
  output logic [7:0]                           dat,
  output logic [$clog2(NCH)+$clog2(LINE)-1:0]  addr,
  output logic                                 we
);
  localparam int IW = W - FRAC;
  localparam int LW = $clog2(LINE);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int AW = $clog2(NCH) + LW;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_CHR  = 3'd2;
  localparam logic [2:0] S_ISUB = 3'd3;
  localparam logic [2:0] S_FMUL = 3'd4;
  localparam logic [2:0] S_FWR  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  function automatic logic [63:0] pow10(input int k);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < k; i++) r = r * 64'd10;
    return r;
  endfunction

  logic [2:0]       state;
  logic [W*NCH-1:0] vals;
  logic [NCH-1:0]   sgn;
  logic [8*NCH-1:0] labs;
  logic [CW-1:0]    ch;
  logic [LW-1:0]    col;
  logic [IW-1:0]    rem;
  logic [FRAC-1:0]  frac;
  logic [FRAC+3:0]  prod;
  logic [3:0]       d;
  logic             neg, ovf, blank, ge, last_ch, last_col;
  logic [W-1:0]     v, mag;
  logic [63:0]      pw;
  logic [2:0]       nxt;
  int               ci, ncol;

  always_comb begin
    ci = int'(col);
    ncol = ci + 1;
    v = vals[ch*W +: W];
    mag = sgn[ch] && v[W-1] ? -v : v;
    pw = '0;
    for (int i = 0; i < IDIG; i++) if (ci == IDIG + 2 - i) pw = pow10(i);
    ge = 64'(rem) >= pw;
    last_ch = int'(ch) == NCH - 1;
    last_col = ci == LINE - 1;
    nxt = ncol >= 3 && ncol <= IDIG + 2 ? S_ISUB :
          ncol >= IDIG + 4 && ncol < IDIG + FDIG + 4 ? (ovf ? S_FWR : S_FMUL) : S_CHR;
    we = state == S_CHR || state == S_FWR || (state == S_ISUB && (ovf || !ge));
    dat = !we ? 8'h00 :
          state == S_CHR ? (ci == 0 ? labs[ch*8 +: 8] : ci == 1 ? ":" : ci == 2 ? (neg ? "-" : " ") :
                            ci == IDIG + 3 ? "." : " ") :
          ovf ? "#" :
          state == S_FWR ? 8'h30 + {4'h0, prod[FRAC+3:FRAC]} :
          blank ? " " : 8'h30 + {4'h0, d};
    addr = (AW'(ch) << LW) | AW'(col);
    busy = state != S_IDLE && state != S_DONE;
    done = state == S_DONE;
  end

`ifdef LCD_FMT_LEADZ_BLANK_EN
  logic lead;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lead <= 1'b0;
    else if (state == S_LOAD) lead <= 1'b1;
    else if (state == S_ISUB && we && d != 4'd0) lead <= 1'b0;
  assign blank = lead && d == 4'd0 && ci != IDIG + 2;
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      vals  <= '0;
      sgn   <= '0;
      labs  <= '0;
      ch    <= '0;
      col   <= '0;
      rem   <= '0;
      frac  <= '0;
      prod  <= '0;
      d     <= '0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE:
          if (start) begin
            vals  <= values;
            sgn   <= is_signed;
            labs  <= labels;
            ch    <= '0;
            state <= S_LOAD;
          end else state <= S_IDLE;
        S_LOAD: begin
          neg   <= sgn[ch] && v[W-1];
          rem   <= mag[W-1:FRAC];
          frac  <= mag[FRAC-1:0];
          ovf   <= 64'(mag[W-1:FRAC]) >= pow10(IDIG);
          col   <= '0;
          d     <= '0;
          state <= S_CHR;
        end
        S_ISUB:
          if (!we) begin
            rem <= rem - IW'(pw);
            d   <= d + 4'd1;
          end
        S_FMUL: begin
          prod  <= {4'h0, frac} * (FRAC+4)'(10);
          state <= S_FWR;
        end
        S_FWR: frac <= prod[FRAC-1:0];
        default: ;
      endcase
      // a write always closes the current column; channel stepping happens on the last one
      if (we) begin
        d   <= '0;
        col <= last_col ? '0 : col + 1'b1;
        if (last_col) begin
          ch    <= last_ch ? ch : ch + 1'b1;
          state <= last_ch ? S_DONE : S_LOAD;
        end else state <= nxt;
      end
    end
endmodule

// File: tb/tb_lcd_fixed_formatter.sv
// tb_lcd_fixed_formatter: table-driven checks of text output, timing, handshake, overflow and reset abort.
module tb_lcd_fixed_formatter;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0;
  logic [63:0] values = '0;
  logic [1:0]  is_signed = '0;
  logic [15:0] labels = '0;
  logic        busy, done, we;
  logic [7:0]  dat;
  logic [4:0]  addr;
  logic [31:0] values2 = '0;
  logic [0:0]  is_signed2 = 1'b1;
  logic [7:0]  labels2 = "X";
  logic        busy2, done2, we2;
  logic [7:0]  dat2;
  logic [3:0]  addr2;

  always #5 clk = ~clk;

  lcd_fixed_formatter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .values(values), .is_signed(is_signed),
    .labels(labels), .busy(busy), .done(done), .dat(dat), .addr(addr), .we(we)
  );

  lcd_fixed_formatter #(.NCH(1), .IDIG(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .values(values2), .is_signed(is_signed2),
    .labels(labels2), .busy(busy2), .done(done2), .dat(dat2), .addr(addr2), .we(we2)
  );

  int tests = 0, fails = 0;
  int cyc = 0;
  int nwr, first_cyc, last_cyc, done_cyc, dups, first_addr, busy_at_done, ndone;
  int nwr2, done2_cyc, dups2;
  logic [7:0]  scr [32];
  logic [7:0]  scr2 [16];
  logic [31:0] seen;
  logic [15:0] seen2;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) begin
      if (seen[addr]) dups++;
      seen[addr] = 1'b1;
      scr[addr] = dat;
      if (nwr == 0) begin
        first_cyc = cyc;
        first_addr = int'(addr);
      end
      last_cyc = cyc;
      nwr++;
    end
    if (done) begin
      ndone++;
      if (done_cyc < 0) begin
        done_cyc = cyc;
        busy_at_done = int'(busy);
      end
    end
    if (we2) begin
      if (seen2[addr2]) dups2++;
      seen2[addr2] = 1'b1;
      scr2[addr2] = dat2;
      nwr2++;
    end
    if (done2 && done2_cyc < 0) done2_cyc = cyc;
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chks(input string nm, input string got, input string exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", nm, got, exp);
    end
  endtask

  function automatic string line(input int l);
    string s = "";
    for (int i = 0; i < 16; i++) s = $sformatf("%s%c", s, scr[l*16+i]);
    return s;
  endfunction

  function automatic string line2();
    string s = "";
    for (int i = 0; i < 16; i++) s = $sformatf("%s%c", s, scr2[i]);
    return s;
  endfunction

`ifdef LCD_FMT_LEADZ_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  function automatic string fix(input string s, input int idig);
    string r = s;
    for (int i = 3; BLANK && i < 2 + idig && r.getc(i) == 8'h30; i++) r.putc(i, 8'h20);
    return r;
  endfunction

  task automatic clr();
    for (int i = 0; i < 32; i++) scr[i] = 8'h3F;
    seen = '0; nwr = 0; dups = 0; done_cyc = -1; ndone = 0;
    first_cyc = -1; last_cyc = -1; first_addr = -1; busy_at_done = -1;
  endtask

  task automatic clr2();
    for (int i = 0; i < 16; i++) scr2[i] = 8'h3F;
    seen2 = '0; nwr2 = 0; dups2 = 0; done2_cyc = -1;
  endtask

  task automatic launch(input logic [63:0] v, input logic [1:0] s, input logic [15:0] l, output int t0);
    @(posedge clk); #1;
    values = v; is_signed = s; labels = l; start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; values = ~v; is_signed = ~s; labels = ~l;
  endtask

  task automatic wait_done(input string nm);
    for (int k = 0; k < 400 && done_cyc < 0; k++) @(posedge clk);
    chk({nm, " done seen"}, done_cyc >= 0, 1);
  endtask

  task automatic run_conv(input string nm, input logic [63:0] v, input logic [1:0] s,
                          input logic [15:0] l, input string e0, input string e1);
    int t0;
    clr();
    launch(v, s, l, t0);
    chk({nm, " busy after start"}, busy, 1);
    wait_done(nm);
    chks({nm, " line0"}, line(0), fix(e0, 5));
    chks({nm, " line1"}, line(1), fix(e1, 5));
    chk({nm, " writes"}, nwr, 32);
    chk({nm, " first write latency"}, first_cyc - t0, 2);
    chk({nm, " first addr"}, first_addr, 0);
    chk({nm, " done after last write"}, done_cyc - last_cyc, 1);
    chk({nm, " busy at done"}, busy_at_done, 0);
    chk({nm, " duplicate addrs"}, dups, 0);
  endtask

  task automatic run2(input string nm, input logic [31:0] v, input string e, input int exp_cycles);
    int t0;
    clr2();
    @(posedge clk); #1;
    values2 = v; start2 = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start2 = 1'b0; values2 = ~v;
    for (int k = 0; k < 400 && done2_cyc < 0; k++) @(posedge clk);
    chk({nm, " done seen"}, done2_cyc >= 0, 1);
    chks({nm, " line"}, line2(), fix(e, 4));
    chk({nm, " writes"}, nwr2, 16);
    chk({nm, " duplicate addrs"}, dups2, 0);
    if (exp_cycles > 0) chk({nm, " start to done"}, done2_cyc - t0, exp_cycles);
  endtask

  typedef struct {
    logic [63:0] v;
    logic [1:0]  s;
    logic [15:0] l;
    string       e0;
    string       e1;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int t0;
    tbl[0] = '{{32'h8000_0000, 32'h0001_8000}, 2'b11, {"Y", "X"}, "X: 00001.5000   ", "Y:-32768.0000   "};
    tbl[1] = '{{32'hFFFF_FFFF, 32'hFFFE_8000}, 2'b01, {"Y", "X"}, "X:-00001.5000   ", "Y: 65535.9999   "};
    tbl[2] = '{{32'h0000_0000, 32'hFFFF_FFFF}, 2'b10, {"Z", "X"}, "X: 65535.9999   ", "Z: 00000.0000   "};
    tbl[3] = '{{32'h000A_4000, 32'h0000_0001}, 2'b11, {"B", "A"}, "A: 00000.0000   ", "B: 00010.2500   "};
    tbl[4] = '{{32'h7FFF_FFFF, 32'hFFFF_FFFF}, 2'b11, {"Y", "X"}, "X:-00000.0000   ", "Y: 32767.9999   "};
    clr();
    clr2();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset we", we, 0);
    chk("reset dat", dat, 0);
    chk("reset addr", addr, 0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_conv($sformatf("vec%0d", i), tbl[i].v, tbl[i].s, tbl[i].l, tbl[i].e0, tbl[i].e1);

    run2("ovf 12345", 32'h3039_0000, "X: ####.####    ", 0);
    run2("ovf 10000", 32'h2710_0000, "X: ####.####    ", 0);
    run2("max 9999.5", 32'h270F_8000, "X: 9999.5000    ", 58);

    // start pulse while busy must be neither honoured nor queued
    clr();
    launch(tbl[0].v, tbl[0].s, tbl[0].l, t0);
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("busy start");
    repeat (30) @(posedge clk);
    chk("busy start writes", nwr, 32);
    chk("busy start done pulses", ndone, 1);
    chks("busy start line1", line(1), fix(tbl[0].e1, 5));

    // reset abort after the 10th write
    clr();
    launch(tbl[1].v, tbl[1].s, tbl[1].l, t0);
    for (int k = 0; k < 200 && nwr < 10; k++) begin
      @(negedge clk); #1;
    end
    chk("abort tenth write reached", nwr, 10);
    rst_n = 1'b0;
    #1;
    chk("abort we", we, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    repeat (5) @(posedge clk);
    #1 chk("abort no further writes", nwr, 10);
    rst_n = 1'b1;
    run_conv("after abort", tbl[2].v, tbl[2].s, tbl[2].l, tbl[2].e0, tbl[2].e1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failed %0d of %0d so far", fails, tests);
    $fatal(1);
  end
endmodule
